setpoint_slew_limiter: RTL
==========================

// Module: setpoint_slew_limiter
// PURPOSE
//  Sits directly downstream of the 8-way 12-bit setpoint multiplexer and feeds the regulator loop.
//  Ramps its output setpoint toward the selected target at a bounded rate.
//  This gives soft-start at power-up and smooth transitions when the setpoint selection changes.
//  Prevents step changes on the reference input and the resulting output overshoot.
// PARAMETERS
//  WIDTH     12    setpoint width in bits
//  STEP      8     maximum change of setpoint per tick, in LSB (1..2^WIDTH-1)
//  TICK_DIV  1000  clock cycles per tick (>=1); STEP/TICK_DIV sets the slew rate
//  VMAX      4095  upper clamp applied to target (<=2^WIDTH-1)
//  INIT_VAL  0     setpoint value after reset (<=VMAX)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      1 = ramping enabled; 0 = freeze setpoint
//  target     in   WIDTH  requested setpoint from setpoint mux
//  setpoint   out  WIDTH  rate-limited setpoint to regulator (registered)
//  busy       out  1      1 while state is RAMP_UP or RAMP_DOWN (registered)
//  at_target  out  1      1 when setpoint == clamped target (registered)
// BEHAVIOUR
//  Reset (async, immediate):
//   - setpoint = INIT_VAL, busy = 0, at_target = 0.
//   - Tick counter = 0, state = IDLE.
//  Clamp: tgt_c = (target > VMAX) ? VMAX : target (combinational, unsigned compare).
//  Tick counter:
//   - While en=1, counts 0..TICK_DIV-1 and wraps.
//   - tick is asserted for one cycle when count == TICK_DIV-1.
//   - TICK_DIV=1 gives a tick every cycle.
//   - en=0 clears the counter and suppresses tick.
//  State machine (state is registered; next state is computed every cycle from setpoint vs tgt_c):
//   - IDLE: entered when setpoint == tgt_c.
//   - RAMP_UP: entered when setpoint < tgt_c and en=1.
//   - RAMP_DOWN: entered when setpoint > tgt_c and en=1.
//   - en=0 forces IDLE regardless of the compare; setpoint is held.
//  Update on tick:
//   - tgt_c is sampled on the tick cycle itself.
//   - If tgt_c > setpoint: setpoint += min(STEP, tgt_c - setpoint).
//   - If tgt_c < setpoint: setpoint -= min(STEP, setpoint - tgt_c).
//   - If equal: setpoint is held.
//   - Difference arithmetic is WIDTH+1 bits, so setpoint never overshoots, wraps or underflows.
//  Registered flags:
//   - at_target and busy reflect the registered setpoint one cycle after it changes.
//   - busy = 0 and at_target = 0 are both legal (en=0 while not at target).
//  Target changes mid-ramp:
//   - The new target takes effect at the next tick.
//   - Direction may reverse on that tick; no extra delay, no counter restart.
//  Simultaneous events:
//   - rst wins over everything.
//   - en falling on a tick cycle: that update is suppressed.
//  Latency:
//   - Target change to first setpoint movement: at most TICK_DIV cycles.
//   - Full-scale ramp: ceil(|delta|/STEP) ticks.
// TESTING (STEP=8, TICK_DIV=4, VMAX=3000, INIT_VAL=0 unless stated)
//  1. rst pulse mid-cycle -> setpoint=0, busy=0, at_target=0 immediately, before the next clk edge.
//  2. en=1, target=100 -> setpoint steps 8,16,...,96 every 4 clks, then 100 (13th tick);
//     at_target=1 and busy=0 one clk later; no value >100 ever appears.
//  3. From 100, target=0 -> setpoint 92,84,...,4,0 every 4 clks; never wraps to 4095.
//  4. Ramp up to target=200; at setpoint=48 change target=20 -> next tick setpoint=40, then 32,24,20;
//     state goes RAMP_UP -> RAMP_DOWN -> IDLE.
//  5. target=4095 -> setpoint stops at 3000, at_target=1;
//     drop en for 10 ticks mid-ramp -> setpoint frozen and busy=0 during that window.
//  6. rst asserted at setpoint=56 while ramping -> setpoint=0 at once;
//     after release, ramp restarts from 0 with first step 4 clks later.

Source files
------------

// File: rtl/setpoint_slew_limiter.sv
// Rate-limited setpoint ramp between the setpoint mux and the regulator loop.
// The setpoint moves at most STEP LSB toward the clamped target once every TICK_DIV cycles.
module setpoint_slew_limiter #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned STEP     = 8,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned VMAX     = 4095,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] setpoint,
  output logic             busy,
  output logic             at_target
);

  localparam int unsigned      CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] VMAX_C   = WIDTH'(VMAX);
  localparam logic [WIDTH-1:0] INIT_C   = WIDTH'(INIT_VAL);
  localparam logic [WIDTH:0]   STEP_C   = (WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic             busy_q, busy_d;
  logic             at_q, at_d;
  logic [WIDTH-1:0] tgt_c;
  logic             tick;
  logic [WIDTH:0]   diff_up, diff_dn;

  always_comb begin
    tgt_c = (target > VMAX_C) ? VMAX_C : target;
    tick  = en && (cnt_q == CNT_LAST);

    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 1'b1;

    // One extra bit keeps the distance and the stepped value free of wrap.
    diff_up = {1'b0, tgt_c} - {1'b0, sp_q};
    diff_dn = {1'b0, sp_q} - {1'b0, tgt_c};

    sp_d = sp_q;
    if (tick) begin
      if (tgt_c > sp_q)
        sp_d = (diff_up > STEP_C) ? WIDTH'({1'b0, sp_q} + STEP_C) : tgt_c;
      else if (tgt_c < sp_q)
        sp_d = (diff_dn > STEP_C) ? WIDTH'({1'b0, sp_q} - STEP_C) : tgt_c;
    end

    state_d = IDLE;
    if (en) begin
      if (sp_q < tgt_c)      state_d = RAMP_UP;
      else if (sp_q > tgt_c) state_d = RAMP_DOWN;
    end

    busy_d = (state_d != IDLE);
    at_d   = (sp_q == tgt_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sp_q    <= INIT_C;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
    end
  end

  assign setpoint  = sp_q;
  assign busy      = busy_q;
  assign at_target = at_q;

endmodule
